// File: rtl/full_xor_pkg.sv
// rtl/full_xor_pkg.sv - sizing and random-word indexing helpers for the full_xor_pipe refresh network.
package full_xor_pkg;

   function automatic int calc_layers(input int n_shares);
      return $clog2(n_shares);
   endfunction

   function automatic int calc_randnum(input int n_shares);
      return $clog2(n_shares) * (n_shares / 2);
   endfunction

   // Word consumed by pair `pair` of refresh layer `layer`.
   function automatic int rnd_idx(input int n_shares, input int layer, input int pair);
      return layer * (n_shares / 2) + pair;
   endfunction

endpackage

// File: rtl/full_xor_pipe_if.sv
// rtl/full_xor_pipe_if.sv - input/output handshake bundle of full_xor_pipe.
interface full_xor_pipe_if #(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 4,
   parameter int RANDNUM  = full_xor_pkg::calc_randnum(N_SHARES)
);
   logic                        flush;
   logic                        in_valid;
   logic                        in_ready;
   logic [K_WIDTH*N_SHARES-1:0] i_x;
   logic [K_WIDTH*RANDNUM-1:0]  rnd;
   logic                        out_valid;
   logic                        out_ready;
   logic [K_WIDTH-1:0]          o_z;
   logic [15:0]                 o_cnt;

   modport master (
      output flush, in_valid, i_x, rnd, out_ready,
      input  in_ready, out_valid, o_z, o_cnt
   );

   modport slave (
      input  flush, in_valid, i_x, rnd, out_ready,
      output in_ready, out_valid, o_z, o_cnt
   );
endinterface

// File: rtl/full_xor_stage.sv
// rtl/full_xor_stage.sv - one share-refresh layer with its elastic register stage.
// Optional FULL_XOR_PIPE_ZEROIZE_EN clears data/randomness whenever the stage is empty.
module full_xor_stage
   import full_xor_pkg::*;
#(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 4,
   parameter int RANDNUM  = calc_randnum(4),
   parameter int LAYER    = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        up_valid,
   output logic                        up_ready,
   input  logic [K_WIDTH*N_SHARES-1:0] up_data,
   input  logic [K_WIDTH*RANDNUM-1:0]  up_rnd,
   output logic                        dn_valid,
   input  logic                        dn_ready,
   output logic [K_WIDTH*N_SHARES-1:0] dn_data,
   output logic [K_WIDTH*RANDNUM-1:0]  dn_rnd
);
   localparam int DW        = K_WIDTH * N_SHARES;
   localparam int RW        = K_WIDTH * RANDNUM;
   localparam int STRIDE    = 1 << LAYER;
   localparam int KEEP_FROM = rnd_idx(N_SHARES, LAYER + 1, 0);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d, refreshed;
   logic [RW-1:0] rnd_q, rnd_d, kept_rnd;

   assign up_ready = !valid_q || dn_ready;
   assign dn_valid = valid_q;
   assign dn_data  = data_q;
   assign dn_rnd   = rnd_q;

   // Pair index counts partners i (bit LAYER clear) in ascending order.
   always_comb begin
      refreshed = up_data;
      for (int i = 0; i < N_SHARES; i++) begin
         if ((i & STRIDE) == 0) begin
            refreshed[i*K_WIDTH +: K_WIDTH] = up_data[i*K_WIDTH +: K_WIDTH]
               ^ up_rnd[rnd_idx(N_SHARES, LAYER, ((i >> (LAYER + 1)) << LAYER) + (i & (STRIDE - 1)))*K_WIDTH +: K_WIDTH];
            refreshed[(i+STRIDE)*K_WIDTH +: K_WIDTH] = up_data[(i+STRIDE)*K_WIDTH +: K_WIDTH]
               ^ up_rnd[rnd_idx(N_SHARES, LAYER, ((i >> (LAYER + 1)) << LAYER) + (i & (STRIDE - 1)))*K_WIDTH +: K_WIDTH];
         end
      end
   end

   always_comb begin
      kept_rnd = '0;
      for (int r = 0; r < RANDNUM; r++) begin
         kept_rnd[r*K_WIDTH +: K_WIDTH] = (r >= KEEP_FROM) ? up_rnd[r*K_WIDTH +: K_WIDTH] : '0;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      rnd_d   = rnd_q;
      if (flush) begin
         valid_d = 1'b0;
`ifdef FULL_XOR_PIPE_ZEROIZE_EN
         data_d  = '0;
         rnd_d   = '0;
`endif
      end else if (up_ready) begin
         valid_d = up_valid;
         if (up_valid) begin
            data_d = refreshed;
            rnd_d  = kept_rnd;
         end
`ifdef FULL_XOR_PIPE_ZEROIZE_EN
         else begin
            data_d = '0;
            rnd_d  = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         rnd_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         rnd_q   <= rnd_d;
      end
   end
endmodule

// File: rtl/full_xor_pipe.sv
// rtl/full_xor_pipe.sv - elastic masked-share refresh pipeline that unmasks to the XOR of all shares.
// Optional FULL_XOR_PIPE_ZEROIZE_EN zeroes empty stages so o_z reads 0 while out_valid is low.
module full_xor_pipe
   import full_xor_pkg::*;
#(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 4,
   parameter int LAYERS   = calc_layers(N_SHARES),
   parameter int RANDNUM  = calc_randnum(N_SHARES)
) (
   input  logic           clk,
   input  logic           rst,
   full_xor_pipe_if.slave bus
);
   localparam int DW = K_WIDTH * N_SHARES;
   localparam int RW = K_WIDTH * RANDNUM;

   logic          valid_c [LAYERS+1];
   logic          ready_c [LAYERS+1];
   logic [DW-1:0] data_c  [LAYERS+1];
   logic [RW-1:0] rnd_c   [LAYERS+1];
   logic [K_WIDTH-1:0] z;
   logic [15:0]   cnt_q, cnt_d;

   assign valid_c[0]      = bus.in_valid;
   assign data_c[0]       = bus.i_x;
   assign rnd_c[0]        = bus.rnd;
   assign ready_c[LAYERS] = bus.out_ready;
   // Flush owns the cycle: nothing may enter while the pipe is being emptied.
   assign bus.in_ready    = ready_c[0] && !bus.flush;

   for (genvar l = 0; l < LAYERS; l++) begin : g_layer
      full_xor_stage #(
         .K_WIDTH  (K_WIDTH),
         .N_SHARES (N_SHARES),
         .RANDNUM  (RANDNUM),
         .LAYER    (l)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (bus.flush),
         .up_valid (valid_c[l]),
         .up_ready (ready_c[l]),
         .up_data  (data_c[l]),
         .up_rnd   (rnd_c[l]),
         .dn_valid (valid_c[l+1]),
         .dn_ready (ready_c[l+1]),
         .dn_data  (data_c[l+1]),
         .dn_rnd   (rnd_c[l+1])
      );
   end

   always_comb begin
      z = '0;
      for (int j = 0; j < N_SHARES; j++) begin
         z = z ^ data_c[LAYERS][j*K_WIDTH +: K_WIDTH];
      end
   end

   assign bus.o_z       = z;
   assign bus.out_valid = valid_c[LAYERS];
   assign bus.o_cnt     = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_full_xor_pipe.sv
// tb/tb_full_xor_pipe.sv - self-checking bench: queue model of unmasked results for two configurations.
module tb_full_xor_pipe;
   logic clk = 1'b0;
   logic rst1 = 1'b1;
   logic rst2 = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   acc2  = 0;
   bit   done2 = 1'b0;

   always #5 clk = ~clk;

   full_xor_pipe_if #(.K_WIDTH(32), .N_SHARES(4)) bus1 ();
   full_xor_pipe_if #(.K_WIDTH(8),  .N_SHARES(8)) bus2 ();

   full_xor_pipe #(.K_WIDTH(32), .N_SHARES(4)) u1 (.clk(clk), .rst(rst1), .bus(bus1));
   full_xor_pipe #(.K_WIDTH(8),  .N_SHARES(8)) u2 (.clk(clk), .rst(rst2), .bus(bus2));

   logic [31:0] q1 [$];
   logic [7:0]  q2 [$];
   logic [15:0] cnt1 = '0;
   logic [15:0] cnt2 = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fold1(input logic [127:0] x);
      logic [31:0] a = '0;
      for (int j = 0; j < 4; j++) a ^= x[j*32 +: 32];
      return a;
   endfunction

   function automatic logic [7:0] fold2(input logic [63:0] x);
      logic [7:0] a = '0;
      for (int j = 0; j < 8; j++) a ^= x[j*8 +: 8];
      return a;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Compare, then advance the model by what the coming edge will transfer.
   always @(negedge clk) begin
      if (!rst1) begin
         if (bus1.out_valid) begin
            if (q1.size() == 0) chk("u1_spurious_out", bus1.out_valid, 1'b0);
            else                chk("u1_o_z", bus1.o_z, q1[0]);
         end
         chk("u1_o_cnt", bus1.o_cnt, cnt1);
`ifdef FULL_XOR_PIPE_ZEROIZE_EN
         if (!bus1.out_valid) chk("u1_zeroized_o_z", bus1.o_z, 32'h0);
`endif
      end
      if (!rst2) begin
         if (bus2.out_valid) begin
            if (q2.size() == 0) chk("u2_spurious_out", bus2.out_valid, 1'b0);
            else                chk("u2_o_z", bus2.o_z, q2[0]);
         end
         chk("u2_o_cnt", bus2.o_cnt, cnt2);
`ifdef FULL_XOR_PIPE_ZEROIZE_EN
         if (!bus2.out_valid) chk("u2_zeroized_o_z", bus2.o_z, 8'h0);
`endif
      end

      if (rst1) begin
         q1.delete();
         cnt1 = '0;
      end else if (bus1.flush) begin
         q1.delete();
      end else begin
         if (bus1.out_valid && bus1.out_ready && q1.size() > 0) begin
            void'(q1.pop_front());
            cnt1 = cnt1 + 16'd1;
         end
         if (bus1.in_valid && bus1.in_ready) q1.push_back(fold1(bus1.i_x));
      end

      if (rst2) begin
         q2.delete();
         cnt2 = '0;
      end else if (bus2.flush) begin
         q2.delete();
      end else begin
         if (bus2.out_valid && bus2.out_ready && q2.size() > 0) begin
            void'(q2.pop_front());
            cnt2 = cnt2 + 16'd1;
         end
         if (bus2.in_valid && bus2.in_ready) begin
            q2.push_back(fold2(bus2.i_x));
            acc2++;
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   // Configuration N=8, K=8: random traffic with a reset in the middle.
   initial begin
      bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
      bus2.i_x = '0; bus2.rnd = '0;
      repeat (3) @(posedge clk);
      #1 rst2 = 1'b0;
      for (int c = 0; c < 1800; c++) begin
         @(posedge clk); #1;
         rst2           = (c == 700);
         bus2.in_valid  = ($urandom_range(0, 4) != 0);
         bus2.out_ready = ($urandom_range(0, 4) != 0);
         bus2.i_x       = {$urandom, $urandom};
         bus2.rnd       = {$urandom, $urandom, $urandom};
         @(negedge clk);
         if (c == 701) begin
            chk("u2_rst_out_valid", bus2.out_valid, 1'b0);
            chk("u2_rst_o_cnt", bus2.o_cnt, 16'h0);
         end
      end
      @(posedge clk); #1;
      bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("u2_drained", q2.size(), 0);
      chk("u2_enough_txns", acc2 >= 1000, 1'b1);
      done2 = 1'b1;
   end

   initial begin
      logic [31:0] held;
      bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
      bus1.i_x = '0; bus1.rnd = '0;
      repeat (3) @(posedge clk);
      #1 rst1 = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", bus1.out_valid, 1'b0);
      chk("reset_o_z", bus1.o_z, 32'h0);
      chk("reset_o_cnt", bus1.o_cnt, 16'h0);
      chk("reset_in_ready", bus1.in_ready, 1'b1);

      // Single transaction, two-cycle latency.
      @(posedge clk); #1;
      bus1.in_valid = 1'b1;
      bus1.i_x = {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};
      bus1.rnd = rand128();
      @(negedge clk);
      chk("single_accept", bus1.in_ready, 1'b1);
      @(posedge clk); #1 bus1.in_valid = 1'b0;
      @(negedge clk);
      chk("single_t1_out_valid", bus1.out_valid, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_t2_out_valid", bus1.out_valid, 1'b1);
      chk("single_o_z", bus1.o_z, 32'hFFFFFFFF);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_o_cnt", bus1.o_cnt, 16'd1);

      // Ten back-to-back transactions.
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         bus1.in_valid = (i < 10);
         bus1.i_x = rand128();
         bus1.rnd = rand128();
         @(negedge clk);
         if (i >= 2) chk("stream_out_valid", bus1.out_valid, 1'b1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("stream_o_cnt", bus1.o_cnt, 16'd11);
      chk("stream_idle", bus1.out_valid, 1'b0);

      // Backpressure with the pipe full.
      @(posedge clk); #1;
      bus1.out_ready = 1'b0; bus1.in_valid = 1'b1;
      bus1.i_x = rand128(); bus1.rnd = rand128();
      @(posedge clk); #1;
      bus1.i_x = rand128(); bus1.rnd = rand128();
      @(posedge clk); #1;
      bus1.i_x = rand128(); bus1.rnd = rand128();
      @(negedge clk);
      held = bus1.o_z;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("stall_in_ready", bus1.in_ready, 1'b0);
         chk("stall_out_valid", bus1.out_valid, 1'b1);
         chk("stall_o_z_held", bus1.o_z, held);
         @(posedge clk); #1;
      end
      bus1.out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", bus1.in_ready, 1'b1);
      @(posedge clk); #1 bus1.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("release_o_cnt", bus1.o_cnt, 16'd14);
      chk("release_drained", q1.size(), 0);

      // Flush with two transactions in flight and a third offered.
      @(posedge clk); #1;
      bus1.out_ready = 1'b0; bus1.in_valid = 1'b1;
      bus1.i_x = rand128(); bus1.rnd = rand128();
      @(posedge clk); #1;
      bus1.i_x = rand128(); bus1.rnd = rand128();
      @(posedge clk); #1;
      bus1.flush = 1'b1;
      bus1.i_x = rand128(); bus1.rnd = rand128();
      @(negedge clk);
      chk("flush_in_ready", bus1.in_ready, 1'b0);
      @(posedge clk); #1;
      bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
      @(negedge clk);
      chk("flush_out_valid", bus1.out_valid, 1'b0);
      chk("flush_o_cnt", bus1.o_cnt, 16'd14);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("flush_nothing_left", bus1.out_valid, 1'b0);

      // Counter wrap: bring o_cnt to 0xFFFF, then one more.
      @(posedge clk); #1;
      bus1.in_valid = 1'b1;
      for (int i = 0; i < 65521; i++) begin
         bus1.i_x = rand128(); bus1.rnd = rand128();
         @(posedge clk); #1;
      end
      bus1.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("wrap_cnt_ffff", bus1.o_cnt, 16'hFFFF);
      @(posedge clk); #1;
      bus1.in_valid = 1'b1;
      bus1.i_x = {32'h0000000F, 32'h000000F0, 32'h00000F00, 32'h0000F000};
      bus1.rnd = rand128();
      @(posedge clk); #1 bus1.in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("wrap_last_o_z", bus1.o_z, 32'h0000FFFF);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wrap_cnt_zero", bus1.o_cnt, 16'h0000);

      wait (done2);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
